l0_fifo_bank: RTL and testbench
===============================

# l0_fifo_bank

Parametrised L0 input buffer bank: `row` independent per-row FIFOs of `depth` entries of `bw` bits each. Rows are written together in one beat and read either all at once or one row per cycle in a diagonal wavefront. It sits between the activation SRAM read port and the west edge of the MAC array. It supersedes the fixed-depth, fixed-stagger L0 buffer with run-time read mode, underflow-safe reads and per-row output valid.

## Interface
- `row`, default 8: number of row FIFOs (≥2).
- `bw`, default 4: bits per row entry.
- `depth`, default 64: entries per row FIFO; power of 2, ≥4.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-low reset. Asserting it clears all state immediately; deassertion is synchronous to `clk` (synchronised upstream).
- `in` input row*bw: write data; row i occupies bits [bw*(i+1)-1 : bw*i].
- `wr` input 1: write request for all rows.
- `rd` input 1: read request; starts one read wavefront.
- `mode` input 1: 0 = parallel (all rows pop together), 1 = staggered (row i pops i cycles after row 0).
- `out` output row*bw: registered read data, same row packing as `in`.
- `o_valid` output row: bit i pulses for one cycle when `out` row i holds newly popped data.
- `o_full` output 1: high when any row FIFO is full.
- `o_ready` output 1: equals !`o_full`.
- `o_empty` output 1: high when every row FIFO is empty.
- `o_err` output 1: sticky error flag (see Configuration).

## Operation
- Each row keeps a write pointer, a read pointer and an occupancy count. Pointers are log2(depth) bits wide and wrap from depth-1 to 0. The count is log2(depth)+1 bits wide, 0..depth.
- Write: when `wr`=1 and `o_full`=0, `in` row i is stored at that row's write pointer in every row. When `wr`=1 and `o_full`=1 the write is dropped for all rows, so rows never diverge on writes.
- Read enable chain `rd_en[row-1:0]`:
  - Parallel mode: every bit loads `rd`.
  - Staggered mode: `rd_en[0]` loads `rd`, and `rd_en[i]` loads `rd_en[i-1]`.
- Pop: when `rd_en[i]`=1 and row i is non-empty, row i updates `out` row i from its read pointer, advances the pointer and sets `o_valid[i]`=1. If row i is empty, the pop is skipped: `out` row i holds its value and `o_valid[i]`=0.
- Simultaneous write and pop on the same row: both happen and the count is unchanged. If the row is empty at that edge, only the write happens; there is no bypass.
- Mode latch: `mode_q` loads `mode` only on edges where `rd_en` is all-zero and `rd`=0. A mode change during a wavefront takes effect after the wavefront drains.
- `o_full` and `o_empty` are combinational from the row counts.

## Timing
- Reset values: `out`=0, `o_valid`=0, `rd_en`=0, all pointers and counts 0, `mode_q`=0, `o_empty`=1, `o_full`=0, `o_ready`=1, `o_err`=0.
- Write latency: `wr` sampled at edge N. The count increments after edge N, and `o_empty` falls in cycle N+1.
- Read latency: `rd` sampled at edge N, so `rd_en` is set in cycle N+1. The pop occurs at edge N+1.
  - Parallel mode: all rows' data and `o_valid` are visible in cycle N+2.
  - Staggered mode: row i is visible in cycle N+2+i.
- Back-to-back `rd` is legal in both modes. In staggered mode wavefronts overlap with one row of spacing.
- Full or empty at depth: after `depth` accepted writes with no pops, `o_full`=1 in the next cycle. A single pop of any row clears `o_full` the cycle after that pop.

## Configuration
- `L0_FIFO_ERR_EN` defined:
  - `o_err` sets on any dropped write (`wr`=1 while `o_full`=1).
  - `o_err` also sets on any skipped pop (`rd_en[i]`=1 on an empty row).
  - It stays set until `reset`.
- `L0_FIFO_ERR_EN` undefined: `o_err` is tied to 0 and no detection logic is built. All other behaviour is identical.

## Test plan
- Reset mid-operation: write 3 beats, assert `reset` low asynchronously between edges → all outputs take reset values immediately; `o_empty`=1 with no clock edge.
- Parallel mode, row=8, bw=4: write `in`=32'h76543210 then 32'hFEDCBA98, pulse `rd` at edge N → in cycle N+2, `out`=32'h76543210 and `o_valid`=8'hFF. A second `rd` returns 32'hFEDCBA98.
- Staggered mode: same data, single `rd` at edge N → `o_valid` is one-hot 8'h01 in cycle N+2, shifting left each cycle to 8'h80 in cycle N+9. `out` row i = i in cycle N+2+i.
- Fill: 64 writes without reads → `o_full`=1 and `o_ready`=0. The 65th write is dropped. After 64 parallel reads the data reads back in order 0..63 and `o_empty`=1; with `L0_FIFO_ERR_EN`, `o_err`=1.
- Underflow: `rd` with an empty bank → `o_valid`=0 and `out` unchanged. `o_err`=1 only when `L0_FIFO_ERR_EN` is defined.
- Mode change mid-wavefront: staggered `rd`, then `mode`=0 at N+3 → rows 0..7 still pop staggered. The next `rd` issued after `rd_en` has drained pops all rows in parallel.

Source files
------------

// File: rtl/l0_fifo_bank.sv
`default_nettype none
// ============================================================================
// Module   : l0_fifo_bank
// Brief    : Bank of per-row L0 FIFOs with a parallel or staggered read
//            wavefront. The optional sticky error flag is enabled by
//            defining L0_FIFO_ERR_EN.
// Revision : 1.0
// ============================================================================
module l0_fifo_bank #(
    parameter int row   = 8,
    parameter int bw    = 4,
    parameter int depth = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [row*bw-1:0]   in,
    input  logic                wr,
    input  logic                rd,
    input  logic                mode,
    output logic [row*bw-1:0]   out,
    output logic [row-1:0]      o_valid,
    output logic                o_full,
    output logic                o_ready,
    output logic                o_empty,
    output logic                o_err
);

    localparam int c_PTR_W = $clog2(depth);
    localparam int c_CNT_W = c_PTR_W + 1;

    logic [row-1:0] r_rd_en;
    logic [row-1:0] w_row_full;
    logic [row-1:0] w_row_empty;
    logic [row-1:0] w_pop;
    logic           r_mode_q;
    logic           w_wr_acc;

    assign o_full   = |w_row_full;
    assign o_ready  = ~o_full;
    assign o_empty  = &w_row_empty;
    // A write is all-or-nothing so the rows always hold the same number of beats written
    assign w_wr_acc = wr & ~o_full;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_en  <= '0;
            r_mode_q <= 1'b0;
        end else begin
            if (r_mode_q) begin
                r_rd_en <= {r_rd_en[row-2:0], rd};
            end else begin
                r_rd_en <= {row{rd}};
            end
            // Only retune the mode while no wavefront is in flight or starting
            if ((r_rd_en == '0) && !rd) begin
                r_mode_q <= mode;
            end
        end
    end

    for (genvar gi = 0; gi < row; gi++) begin : g_row
        logic [bw-1:0]      r_mem [depth];
        logic [c_PTR_W-1:0] r_wptr;
        logic [c_PTR_W-1:0] r_rptr;
        logic [c_CNT_W-1:0] r_cnt;
        logic [bw-1:0]      r_dout;
        logic               r_valid;

        assign w_row_full[gi]    = (r_cnt == c_CNT_W'(depth));
        assign w_row_empty[gi]   = (r_cnt == '0);
        assign w_pop[gi]         = r_rd_en[gi] & ~w_row_empty[gi];
        assign out[bw*gi +: bw]  = r_dout;
        assign o_valid[gi]       = r_valid;

        always_ff @(posedge clk) begin
            if (w_wr_acc) begin
                r_mem[r_wptr] <= in[bw*gi +: bw];
            end
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_wptr  <= '0;
                r_rptr  <= '0;
                r_cnt   <= '0;
                r_dout  <= '0;
                r_valid <= 1'b0;
            end else begin
                r_valid <= w_pop[gi];
                if (w_wr_acc) begin
                    r_wptr <= r_wptr + c_PTR_W'(1);
                end
                if (w_pop[gi]) begin
                    r_dout <= r_mem[r_rptr];
                    r_rptr <= r_rptr + c_PTR_W'(1);
                end
                case ({w_wr_acc, w_pop[gi]})
                    2'b10:   r_cnt <= r_cnt + c_CNT_W'(1);
                    2'b01:   r_cnt <= r_cnt - c_CNT_W'(1);
                    default: r_cnt <= r_cnt;
                endcase
            end
        end
    end

`ifdef L0_FIFO_ERR_EN
    logic r_err;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_err <= 1'b0;
        end else if ((wr & o_full) | (|(r_rd_en & w_row_empty))) begin
            r_err <= 1'b1;
        end
    end

    assign o_err = r_err;
`else
    assign o_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_l0_fifo_bank.sv
`default_nettype none
// Bench for l0_fifo_bank: directed vector table, hand sequences and random
// traffic checked against a queue-level reference model.
module tb_l0_fifo_bank;

    localparam int ROW   = 8;
    localparam int BW    = 4;
    localparam int DEPTH = 64;
    localparam int W     = ROW * BW;

    logic           clk   = 1'b0;
    logic           reset = 1'b0;
    logic           wr    = 1'b0;
    logic           rd    = 1'b0;
    logic           mode  = 1'b0;
    logic [W-1:0]   din   = '0;
    logic [W-1:0]   dout;
    logic [ROW-1:0] valid;
    logic           full, ready, empty, err;

    int ncmp  = 0;
    int nfail = 0;

    l0_fifo_bank #(.row(ROW), .bw(BW), .depth(DEPTH)) dut (
        .clk     (clk),
        .reset   (reset),
        .in      (din),
        .wr      (wr),
        .rd      (rd),
        .mode    (mode),
        .out     (dout),
        .o_valid (valid),
        .o_full  (full),
        .o_ready (ready),
        .o_empty (empty),
        .o_err   (err)
    );

    always #5 clk = ~clk;

    // Reference model: per-row circular stores plus a calendar of pop edges
    logic [BW-1:0]  m_data [ROW][DEPTH];
    int             m_head [ROW];
    int             m_cnt  [ROW];
    logic [BW-1:0]  m_out  [ROW];
    logic [ROW-1:0] m_valid;
    bit             m_mode;
    bit             m_err;
    int             ecnt;
    logic [ROW-1:0] sched [int];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < ROW; i++) begin
            m_head[i] = 0;
            m_cnt[i]  = 0;
            m_out[i]  = '0;
        end
        m_valid = '0;
        m_mode  = 1'b0;
        m_err   = 1'b0;
        ecnt    = 0;
        sched.delete();
    endtask

    task automatic model_edge();
        logic [ROW-1:0] popv;
        logic [ROW-1:0] tmp;
        bit             mfull;
        bit             inflight;
        int             k;
        mfull = 1'b0;
        for (int i = 0; i < ROW; i++) if (m_cnt[i] == DEPTH) mfull = 1'b1;
        inflight = 1'b0;
        for (int e = ecnt; e <= ecnt + ROW; e++) if (sched.exists(e)) inflight = 1'b1;
        popv = '0;
        if (sched.exists(ecnt)) begin
            popv = sched[ecnt];
            sched.delete(ecnt);
        end
        for (int i = 0; i < ROW; i++) begin
            m_valid[i] = 1'b0;
            if (popv[i]) begin
                if (m_cnt[i] > 0) begin
                    m_out[i]   = m_data[i][m_head[i]];
                    m_head[i]  = (m_head[i] + 1) % DEPTH;
                    m_cnt[i]   = m_cnt[i] - 1;
                    m_valid[i] = 1'b1;
                end else begin
`ifdef L0_FIFO_ERR_EN
                    m_err = 1'b1;
`endif
                end
            end
        end
        if (wr) begin
            if (!mfull) begin
                for (int i = 0; i < ROW; i++) begin
                    m_data[i][(m_head[i] + m_cnt[i]) % DEPTH] = din[i*BW +: BW];
                    m_cnt[i] = m_cnt[i] + 1;
                end
            end else begin
`ifdef L0_FIFO_ERR_EN
                m_err = 1'b1;
`endif
            end
        end
        if (rd) begin
            for (int i = 0; i < ROW; i++) begin
                k   = ecnt + 1 + (m_mode ? i : 0);
                tmp = sched.exists(k) ? sched[k] : '0;
                tmp[i] = 1'b1;
                sched[k] = tmp;
            end
        end
        if (!inflight && !rd) m_mode = mode;
        ecnt++;
    endtask

    task automatic model_check();
        logic [W-1:0] eo;
        bit           f;
        bit           e;
        f = 1'b0;
        e = 1'b1;
        for (int i = 0; i < ROW; i++) begin
            eo[i*BW +: BW] = m_out[i];
            if (m_cnt[i] == DEPTH) f = 1'b0 | 1'b1;
            if (m_cnt[i] != 0)     e = 1'b0;
        end
        chk("model_out",   64'(dout),  64'(eo));
        chk("model_valid", 64'(valid), 64'(m_valid));
        chk("model_full",  64'(full),  64'(f));
        chk("model_ready", 64'(ready), 64'(!f));
        chk("model_empty", 64'(empty), 64'(e));
        chk("model_err",   64'(err),   64'(m_err));
    endtask

    // Drive inputs, let one rising edge pass, then compare against the model
    task automatic step(input logic w, input logic r, input logic m, input logic [W-1:0] d);
        wr   = w;
        rd   = r;
        mode = m;
        din  = d;
        @(posedge clk);
        model_edge();
        #1;
        model_check();
    endtask

    typedef struct {
        logic           wr;
        logic           rd;
        logic           mode;
        logic [W-1:0]   din;
        logic [W-1:0]   eout;
        logic [ROW-1:0] evalid;
        logic           eempty;
    } vec_t;

    vec_t tbl [22];

    task automatic setv(input int k, input logic w, input logic r, input logic m,
                        input logic [W-1:0] d, input logic [W-1:0] eo,
                        input logic [ROW-1:0] ev, input logic ee);
        tbl[k].wr     = w;
        tbl[k].rd     = r;
        tbl[k].mode   = m;
        tbl[k].din    = d;
        tbl[k].eout   = eo;
        tbl[k].evalid = ev;
        tbl[k].eempty = ee;
    endtask

    logic [W-1:0] fill_d [DEPTH];
    bit           mcur;

    initial begin
        // Parallel pops, staggered wavefront with a mid-flight mode change,
        // a parallel pop in the re-latched mode, then an underflow read
        setv( 0, 1, 0, 0, 32'h76543210, 32'h00000000, 8'h00, 0);
        setv( 1, 1, 0, 0, 32'hFEDCBA98, 32'h00000000, 8'h00, 0);
        setv( 2, 0, 1, 0, 32'h0,        32'h00000000, 8'h00, 0);
        setv( 3, 0, 0, 0, 32'h0,        32'h76543210, 8'hFF, 0);
        setv( 4, 0, 1, 0, 32'h0,        32'h76543210, 8'h00, 0);
        setv( 5, 0, 0, 0, 32'h0,        32'hFEDCBA98, 8'hFF, 1);
        setv( 6, 1, 0, 1, 32'h76543210, 32'hFEDCBA98, 8'h00, 0);
        setv( 7, 1, 0, 1, 32'hFEDCBA98, 32'hFEDCBA98, 8'h00, 0);
        setv( 8, 0, 1, 1, 32'h0,        32'hFEDCBA98, 8'h00, 0);
        setv( 9, 0, 0, 1, 32'h0,        32'hFEDCBA90, 8'h01, 0);
        setv(10, 0, 0, 1, 32'h0,        32'hFEDCBA10, 8'h02, 0);
        setv(11, 0, 0, 0, 32'h0,        32'hFEDCB210, 8'h04, 0);
        setv(12, 0, 0, 0, 32'h0,        32'hFEDC3210, 8'h08, 0);
        setv(13, 0, 0, 0, 32'h0,        32'hFED43210, 8'h10, 0);
        setv(14, 0, 0, 0, 32'h0,        32'hFE543210, 8'h20, 0);
        setv(15, 0, 0, 0, 32'h0,        32'hF6543210, 8'h40, 0);
        setv(16, 0, 0, 0, 32'h0,        32'h76543210, 8'h80, 0);
        setv(17, 0, 0, 0, 32'h0,        32'h76543210, 8'h00, 0);
        setv(18, 0, 1, 0, 32'h0,        32'h76543210, 8'h00, 0);
        setv(19, 0, 0, 0, 32'h0,        32'hFEDCBA98, 8'hFF, 1);
        setv(20, 0, 1, 0, 32'h0,        32'hFEDCBA98, 8'h00, 1);
        setv(21, 0, 0, 0, 32'h0,        32'hFEDCBA98, 8'h00, 1);

        #1;
        chk("rst_out",   64'(dout),  64'h0);
        chk("rst_valid", 64'(valid), 64'h0);
        chk("rst_empty", 64'(empty), 64'h1);
        chk("rst_full",  64'(full),  64'h0);
        chk("rst_ready", 64'(ready), 64'h1);
        chk("rst_err",   64'(err),   64'h0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        model_reset();

        // Asynchronous reset in the middle of traffic
        step(1, 0, 0, 32'h13579BDF);
        step(1, 0, 0, 32'h2468ACE0);
        step(1, 0, 0, 32'h11223344);
        step(0, 1, 0, 32'h0);
        step(0, 0, 0, 32'h0);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_out",   64'(dout),  64'h0);
        chk("arst_valid", 64'(valid), 64'h0);
        chk("arst_empty", 64'(empty), 64'h1);
        chk("arst_full",  64'(full),  64'h0);
        chk("arst_ready", 64'(ready), 64'h1);
        chk("arst_err",   64'(err),   64'h0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;

        for (int k = 0; k < 22; k++) begin
            step(tbl[k].wr, tbl[k].rd, tbl[k].mode, tbl[k].din);
            chk($sformatf("vec%0d_out", k),   64'(dout),  64'(tbl[k].eout));
            chk($sformatf("vec%0d_valid", k), 64'(valid), 64'(tbl[k].evalid));
            chk($sformatf("vec%0d_empty", k), 64'(empty), 64'(tbl[k].eempty));
        end

        // Fill to depth, drop one write, then drain in order
        for (int k = 0; k < DEPTH; k++) begin
            fill_d[k] = W'($urandom);
            step(1, 0, 0, fill_d[k]);
            if (k == DEPTH - 2) chk("fill_not_full", 64'(full), 64'h0);
        end
        chk("fill_full",  64'(full),  64'h1);
        chk("fill_ready", 64'(ready), 64'h0);
        step(1, 0, 0, 32'hAAAAAAAA);
        chk("drop_full", 64'(full), 64'h1);
        for (int k = 0; k < DEPTH; k++) begin
            step(0, 1, 0, 32'h0);
            if (k >= 1) chk($sformatf("drain%0d", k - 1), 64'(dout), 64'(fill_d[k-1]));
            if (k == 1) chk("full_clear", 64'(full), 64'h0);
        end
        step(0, 0, 0, 32'h0);
        chk("drain63",     64'(dout),  64'(fill_d[DEPTH-1]));
        chk("drain_empty", 64'(empty), 64'h1);
`ifdef L0_FIFO_ERR_EN
        chk("drain_err", 64'(err), 64'h1);
`else
        chk("drain_err", 64'(err), 64'h0);
`endif

        // Random traffic: write-heavy phase then read-heavy phase
        mcur = 1'b0;
        for (int c = 0; c < 800; c++) begin
            logic w;
            logic r;
            if ($urandom_range(0, 31) == 0) mcur = ~mcur;
            if (c < 400) begin
                w = ($urandom_range(0, 1) == 0);
                r = ($urandom_range(0, 3) == 0);
            end else begin
                w = ($urandom_range(0, 3) == 0);
                r = ($urandom_range(0, 1) == 0);
            end
            step(w, r, mcur, W'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
`default_nettype wire
